// File: rtl/multiport_wen_decoder_if.sv
// -----------------------------------------------------------------------------
// multiport_wen_decoder_if
//   Bundles the request side (per-port enables and indices, stall, counter
//   clear) and the registered result side (one-hot vectors, merged write
//   enables, collision flag and counter) of the write-enable decoder.
//
//   Parameters must match the decoder instance bound to the slave modport.
//     SEL_W   index width per port; OUT_W = 2**SEL_W decoded lines
//     NPORTS  number of write ports
//     CNT_W   width of the collision counter
//
//   master : writeback side, drives requests, observes decoded enables
//   slave  : decoder side
// -----------------------------------------------------------------------------
interface multiport_wen_decoder_if #(
  parameter int SEL_W  = 5,
  parameter int NPORTS = 2,
  parameter int CNT_W  = 8
);
  localparam int OUT_W = 1 << SEL_W;

  logic [NPORTS-1:0]       en;
  logic [NPORTS*SEL_W-1:0] sel;
  logic                    stall;
  logic                    clr_cnt;
  logic [NPORTS*OUT_W-1:0] onehot;
  logic [OUT_W-1:0]        wen_any;
  logic                    conflict;
  logic [CNT_W-1:0]        conflict_cnt;

  modport master (
    output en, sel, stall, clr_cnt,
    input  onehot, wen_any, conflict, conflict_cnt
  );

  modport slave (
    input  en, sel, stall, clr_cnt,
    output onehot, wen_any, conflict, conflict_cnt
  );
endinterface

// File: rtl/multiport_wen_decoder.sv
// -----------------------------------------------------------------------------
// multiport_wen_decoder
//   Registered N-port binary-to-one-hot decoder producing register-file write
//   enables. Each port turns its index into a one-hot line; when two ports
//   target the same register, the lower-numbered port keeps the write and
//   the collision is flagged for one cycle and counted in a saturating
//   counter. One cycle of latency, no combinational input-to-output path.
//
// Parameters
//   SEL_W      index width; OUT_W = 2**SEL_W decoded lines
//   NPORTS     number of write ports (1..4)
//   ZERO_MASK  1: index 0 is a hardwired-zero register, never enabled and
//              never a collision; 0: index 0 decoded like any other
//   CNT_W      width of the saturating collision counter
//
// Ports
//   clk    rising-edge clock
//   rst_n  synchronous reset, active low; overrides stall and clr_cnt
//   bus    slave side of multiport_wen_decoder_if
//            en, sel       per-port enable / index (port p at sel[p*SEL_W +: SEL_W])
//            stall         hold every registered output, ignore inputs
//            clr_cnt       clear the collision counter (honoured under stall)
//            onehot        per-port one-hot, port p at onehot[p*OUT_W +: OUT_W]
//            wen_any       OR of all port one-hots
//            conflict      a collision was resolved in the current output
//            conflict_cnt  saturating count of collision events
// -----------------------------------------------------------------------------
module multiport_wen_decoder #(
  parameter int SEL_W     = 5,
  parameter int NPORTS    = 2,
  parameter int ZERO_MASK = 1,
  parameter int CNT_W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  multiport_wen_decoder_if.slave   bus
);

  localparam int               OUT_W   = 1 << SEL_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // ---------------------------------------------------------------------------
  // Combinational decode, priority resolution and collision detection
  // ---------------------------------------------------------------------------
  logic [SEL_W-1:0]        idx [NPORTS];
  logic [OUT_W-1:0]        raw [NPORTS];
  logic [OUT_W-1:0]        claimed;
  logic [NPORTS*OUT_W-1:0] onehot_nxt;
  logic [OUT_W-1:0]        wen_any_nxt;
  logic                    collision;

  // NOTE: every signal driven here gets a default before any conditional
  // assignment, so no path leaves it unassigned and no latch is inferred;
  // combinational blocks use blocking '=' so later statements see the
  // updated values within the same evaluation.
  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      idx[p] = bus.sel[p*SEL_W +: SEL_W];
      raw[p] = '0;
      if (bus.en[p]) begin
        raw[p][idx[p]] = 1'b1;
      end
      if (ZERO_MASK != 0) begin
        raw[p][0] = 1'b0;
      end
    end
  end

  // Lower port index wins: a port only keeps the lines no earlier port has
  // already claimed. Since each raw vector has at most one bit, a losing
  // port ends up all-zero and the slices are disjoint by construction.
  always_comb begin
    claimed    = '0;
    onehot_nxt = '0;
    for (int p = 0; p < NPORTS; p++) begin
      onehot_nxt[p*OUT_W +: OUT_W] = raw[p] & ~claimed;
      claimed                      = claimed | raw[p];
    end
    wen_any_nxt = claimed;
  end

  // A collision is any enabled pair sharing an index, except the masked
  // zero register. Several colliding pairs still form a single event.
  always_comb begin
    collision = 1'b0;
    for (int p = 1; p < NPORTS; p++) begin
      for (int q = 0; q < p; q++) begin
        if (bus.en[p] && bus.en[q] && (idx[p] == idx[q]) &&
            ((idx[p] != '0) || (ZERO_MASK == 0))) begin
          collision = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Counter next-state: a clear lands first, then a same-edge event counts
  // on top of it, so clear plus collision yields 1. Stalled edges never
  // count, which also keeps a held conflict=1 from being counted twice.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_base;
  logic [CNT_W-1:0] cnt_nxt;
  logic             count_evt;

  always_comb begin
    cnt_base  = bus.clr_cnt ? '0 : cnt_q;
    count_evt = !bus.stall && collision;
    cnt_nxt   = cnt_base;
    if (count_evt && (cnt_base != CNT_MAX)) begin
      cnt_nxt = cnt_base + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  logic [NPORTS*OUT_W-1:0] onehot_q;
  logic [OUT_W-1:0]        wen_any_q;
  logic                    conflict_q;

  // NOTE: state registers use non-blocking '<=' so all flops update together
  // from pre-edge values; reset is synchronous, so it is just the highest
  // priority branch inside the clocked block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      onehot_q   <= '0;
      wen_any_q  <= '0;
      conflict_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      if (!bus.stall) begin
        onehot_q   <= onehot_nxt;
        wen_any_q  <= wen_any_nxt;
        conflict_q <= collision;
      end
      cnt_q <= cnt_nxt;
    end
  end

  assign bus.onehot       = onehot_q;
  assign bus.wen_any      = wen_any_q;
  assign bus.conflict     = conflict_q;
  assign bus.conflict_cnt = cnt_q;

endmodule

// File: tb/tb_multiport_wen_decoder.sv
// -----------------------------------------------------------------------------
// tb_multiport_wen_decoder
//   Two decoder instances driven side by side:
//     dut_a  SEL_W=5, NPORTS=2, ZERO_MASK=1, CNT_W=8  (directed decode cases)
//     dut_b  SEL_W=3, NPORTS=4, ZERO_MASK=0, CNT_W=2  (counter saturation)
//   Each clock step a cycle model computes the expected registered state,
//   pushes it to a per-instance queue, and the entry is popped and compared
//   after the edge. Random traffic then exercises both instances.
// -----------------------------------------------------------------------------
module tb_multiport_wen_decoder;

  localparam int A_SEL_W = 5, A_NP = 4'd2, A_ZM = 1, A_CNT_W = 8;
  localparam int B_SEL_W = 3, B_NP = 4, B_ZM = 0, B_CNT_W = 2;

  typedef struct {
    logic [127:0] oh;
    logic [31:0]  wa;
    logic         cf;
    logic [7:0]   cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  multiport_wen_decoder_if #(.SEL_W(A_SEL_W), .NPORTS(A_NP), .CNT_W(A_CNT_W)) if_a ();
  multiport_wen_decoder_if #(.SEL_W(B_SEL_W), .NPORTS(B_NP), .CNT_W(B_CNT_W)) if_b ();

  multiport_wen_decoder #(
    .SEL_W(A_SEL_W), .NPORTS(A_NP), .ZERO_MASK(A_ZM), .CNT_W(A_CNT_W)
  ) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_a.slave)
  );

  multiport_wen_decoder #(
    .SEL_W(B_SEL_W), .NPORTS(B_NP), .ZERO_MASK(B_ZM), .CNT_W(B_CNT_W)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_b.slave)
  );

  int checks   = 0;
  int failures = 0;

  exp_t st_a, st_b;
  exp_t q_a[$];
  exp_t q_b[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Cycle model: next registered state from current state and inputs.
  function automatic exp_t model_next(input exp_t cur, input int np, input int selw,
                                      input int zm, input int cntw, input logic rst_v,
                                      input logic [3:0] en, input logic [19:0] sel,
                                      input logic stall, input logic clr);
    exp_t n;
    int idx[4];
    logic [31:0] taken;
    bit coll;
    int outw;
    int maxc;
    n    = cur;
    outw = 1 << selw;
    maxc = (1 << cntw) - 1;
    if (!rst_v) begin
      n.oh = '0; n.wa = '0; n.cf = 1'b0; n.cnt = '0;
      return n;
    end
    if (clr) n.cnt = '0;
    if (!stall) begin
      n.oh  = '0;
      taken = '0;
      coll  = 0;
      for (int p = 0; p < np; p++)
        idx[p] = int'((sel >> (p * selw)) & ((20'd1 << selw) - 20'd1));
      for (int p = 0; p < np; p++) begin
        if (en[p] && !(zm != 0 && idx[p] == 0)) begin
          if (!taken[idx[p]]) begin
            n.oh[p*outw + idx[p]] = 1'b1;
            taken[idx[p]] = 1'b1;
          end
          for (int q = 0; q < p; q++)
            if (en[q] && idx[q] == idx[p]) coll = 1;
        end
      end
      n.wa = taken;
      n.cf = coll;
      if (coll && int'(n.cnt) < maxc) n.cnt = n.cnt + 8'd1;
    end
    return n;
  endfunction

  // Structural invariants on the observed outputs.
  function automatic bit invariants_ok(input logic [127:0] oh, input logic [31:0] wa,
                                       input int np, input int outw);
    logic [31:0] acc;
    logic [31:0] sl;
    acc = '0;
    for (int p = 0; p < np; p++) begin
      sl = 32'((oh >> (p * outw)) & ((128'd1 << outw) - 128'd1));
      if ($countones(sl) > 1) return 0;
      if ((sl & acc) != 0) return 0;
      acc = acc | sl;
    end
    if (acc != wa) return 0;
    if ($countones(wa) > np) return 0;
    return 1;
  endfunction

  task automatic step();
    exp_t ea, eb;
    st_a = model_next(st_a, A_NP, A_SEL_W, A_ZM, A_CNT_W, rst_n, 4'(if_a.en),
                      20'(if_a.sel), if_a.stall, if_a.clr_cnt);
    st_b = model_next(st_b, B_NP, B_SEL_W, B_ZM, B_CNT_W, rst_n, 4'(if_b.en),
                      20'(if_b.sel), if_b.stall, if_b.clr_cnt);
    q_a.push_back(st_a);
    q_b.push_back(st_b);
    @(posedge clk);
    #1;
    ea = q_a.pop_front();
    eb = q_b.pop_front();
    check("a_onehot",  128'(if_a.onehot),       ea.oh);
    check("a_wen_any", 128'(if_a.wen_any),      128'(ea.wa));
    check("a_conflict",128'(if_a.conflict),     128'(ea.cf));
    check("a_cnt",     128'(if_a.conflict_cnt), 128'(ea.cnt));
    check("b_onehot",  128'(if_b.onehot),       eb.oh);
    check("b_wen_any", 128'(if_b.wen_any),      128'(eb.wa));
    check("b_conflict",128'(if_b.conflict),     128'(eb.cf));
    check("b_cnt",     128'(if_b.conflict_cnt), 128'(eb.cnt));
    check("a_invariants", 128'(invariants_ok(128'(if_a.onehot), 32'(if_a.wen_any), A_NP, 32)), 128'd1);
    check("b_invariants", 128'(invariants_ok(128'(if_b.onehot), 32'(if_b.wen_any), B_NP, 8)), 128'd1);
  endtask

  initial begin
    st_a = '{oh: '0, wa: '0, cf: 1'b0, cnt: '0};
    st_b = '{oh: '0, wa: '0, cf: 1'b0, cnt: '0};

    // Reset dominates a full request with stall asserted.
    rst_n = 1'b0;
    if_a.en = 2'b11; if_a.sel = {5'd4, 5'd4}; if_a.stall = 1'b1; if_a.clr_cnt = 1'b0;
    if_b.en = 4'b0000; if_b.sel = '0; if_b.stall = 1'b0; if_b.clr_cnt = 1'b0;
    #1;
    step();
    step();
    check("rst_onehot",  128'(if_a.onehot),       128'd0);
    check("rst_wen_any", 128'(if_a.wen_any),      128'd0);
    check("rst_conflict",128'(if_a.conflict),     128'd0);
    check("rst_cnt",     128'(if_a.conflict_cnt), 128'd0);

    // Single port, top index.
    rst_n = 1'b1;
    if_a.stall = 1'b0;
    if_a.en = 2'b01; if_a.sel = {5'd0, 5'd31};
    step();
    check("p0_idx31_onehot",  128'(if_a.onehot[31:0]), 128'h8000_0000);
    check("p0_idx31_wen_any", 128'(if_a.wen_any),      128'h8000_0000);
    check("p0_idx31_conflict",128'(if_a.conflict),     128'd0);

    // Sweep of port 0; index 0 is masked.
    for (int k = 0; k < 32; k++) begin
      if_a.sel = {5'd0, 5'(k)};
      step();
      check($sformatf("sweep_%0d", k), 128'(if_a.onehot[31:0]),
            (k == 0) ? 128'd0 : (128'd1 << k));
    end

    // Collision on index 7: port 0 wins.
    if_a.en = 2'b11; if_a.sel = {5'd7, 5'd7};
    step();
    check("coll7_onehot0", 128'(if_a.onehot[31:0]),  128'h80);
    check("coll7_onehot1", 128'(if_a.onehot[63:32]), 128'd0);
    check("coll7_wen_any", 128'(if_a.wen_any),       128'h80);
    check("coll7_conflict",128'(if_a.conflict),      128'd1);
    check("coll7_cnt",     128'(if_a.conflict_cnt),  128'd1);

    // Both ports on the masked zero register: no write, no collision.
    if_a.sel = {5'd0, 5'd0};
    step();
    check("coll0_onehot",  128'(if_a.onehot),       128'd0);
    check("coll0_conflict",128'(if_a.conflict),     128'd0);
    check("coll0_cnt",     128'(if_a.conflict_cnt), 128'd1);

    // Stall holds the registered index 3 while the input changes to 9.
    if_a.en = 2'b01; if_a.sel = {5'd0, 5'd3};
    step();
    check("stall_pre", 128'(if_a.onehot[31:0]), 128'h8);
    if_a.stall = 1'b1; if_a.sel = {5'd0, 5'd9};
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("stall_hold_%0d", i), 128'(if_a.onehot[31:0]), 128'h8);
    end
    if_a.stall = 1'b0;
    step();
    check("stall_release", 128'(if_a.onehot[31:0]), 128'h200);

    // A held conflict=1 under stall is not recounted.
    if_a.en = 2'b11; if_a.sel = {5'd12, 5'd12};
    step();
    if_a.stall = 1'b1;
    step();
    step();
    check("stall_conflict_held", 128'(if_a.conflict),     128'd1);
    check("stall_cnt_no_recount",128'(if_a.conflict_cnt), 128'd2);
    if_a.stall = 1'b0; if_a.en = 2'b00;

    // Two-bit counter saturation on the four-port instance.
    if_b.en = 4'b1111; if_b.sel = {4{3'd5}};
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("sat_cnt_%0d", i), 128'(if_b.conflict_cnt), (i < 3) ? 128'(i + 1) : 128'd3);
    end
    check("sat_onehot", 128'(if_b.onehot), 128'h20);
    if_b.clr_cnt = 1'b1;
    step();
    check("clr_with_coll_cnt", 128'(if_b.conflict_cnt), 128'd1);
    // Clear honoured during stall.
    if_b.stall = 1'b1;
    step();
    check("clr_in_stall_cnt", 128'(if_b.conflict_cnt), 128'd0);
    if_b.clr_cnt = 1'b0; if_b.stall = 1'b0;

    // Mid-stream reset discards the in-flight request.
    if_a.en = 2'b01; if_a.sel = {5'd0, 5'd6};
    rst_n = 1'b0;
    step();
    check("midrst_onehot", 128'(if_a.onehot), 128'd0);
    rst_n = 1'b1;

    // Random traffic on both instances.
    for (int i = 0; i < 10000; i++) begin
      rst_n        = ($urandom_range(0, 499) != 0);
      if_a.en      = 2'($urandom);
      if_a.sel     = ($urandom_range(0, 1) == 0) ? 10'($urandom & 32'h063) : 10'($urandom);
      if_a.stall   = ($urandom_range(0, 3) == 0);
      if_a.clr_cnt = ($urandom_range(0, 31) == 0);
      if_b.en      = 4'($urandom);
      if_b.sel     = 12'($urandom);
      if_b.stall   = ($urandom_range(0, 3) == 0);
      if_b.clr_cnt = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
